// File: rtl/tl_phase_reg.sv
// Phase register and lamp decoder for a traffic light controller with left-turn phases.
// Accepts the next-state logic's ns only after the per-phase dwell timer has expired.
module tl_phase_reg #(
    parameter int unsigned MIN_GRN = 5,
    parameter int unsigned YEL_CYC = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [2:0] ns,
    output logic [2:0] cs,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic       phase_chg
);

    localparam int unsigned TW = 8;
    localparam logic [TW-1:0] TMAX = '1;

    logic [2:0]    r_cs;
    logic [TW-1:0] r_timer;
    logic          r_phase_chg;

    logic [2:0]    w_cs_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic          w_chg_nxt;
    logic [TW-1:0] w_dwell;
    logic          w_expired;
    logic          w_adv;

    // Yellow phases use a fixed dwell; hold phases a minimum dwell.
    assign w_dwell   = r_cs[0] ? TW'(YEL_CYC) : TW'(MIN_GRN);
    assign w_expired = ({1'b0, r_timer} + 9'd1) >= {1'b0, w_dwell};
    assign w_adv     = en && w_expired && (r_cs[0] || (ns != r_cs));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs        <= 3'b000;
            r_timer     <= '0;
            r_phase_chg <= 1'b0;
        end else begin
            r_cs        <= w_cs_nxt;
            r_timer     <= w_timer_nxt;
            r_phase_chg <= w_chg_nxt;
        end
    end

    always_comb begin
        w_cs_nxt    = r_cs;
        w_timer_nxt = r_timer;
        w_chg_nxt   = 1'b0;
        if (w_adv) begin
            w_cs_nxt    = ns;
            w_timer_nxt = '0;
            w_chg_nxt   = 1'b1;
        end else if (en && (r_timer != TMAX)) begin
            w_timer_nxt = r_timer + TW'(1);
        end
    end

    // Lamp codes: 11 green, 10 left arrow, 01 yellow, 00 red.
    always_comb begin
        La = 2'b00;
        Lb = 2'b00;
        unique case (r_cs[1:0])
            2'b00:   if (r_cs[2]) Lb = 2'b11; else La = 2'b11;
            2'b10:   if (r_cs[2]) Lb = 2'b10; else La = 2'b10;
            default: if (r_cs[2]) Lb = 2'b01; else La = 2'b01;
        endcase
    end

    assign cs        = r_cs;
    assign phase_chg = r_phase_chg;

endmodule
